// File: rtl/decoder_buf.sv
// 4-to-16 one-hot decoder feeding a 2-entry valid/ready FIFO.
// Also keeps a modulo-256 count of nonzero words handed downstream.
module decoder_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  code_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] decoder_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  decode_count
);

    logic [15:0] head_q, head_d;
    logic [15:0] tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] decoder_out_q, decoder_out_d;
    logic [7:0]  decode_count_q, decode_count_d;
    logic        accept_s;
    logic        pop_s;
    logic [15:0] new_entry_s;

    function automatic logic [15:0] decode_onehot(input logic [3:0] code, input logic en);
        logic [15:0] word;
        if (en) begin
            word = 16'h0001 << code;
        end else begin
            word = 16'h0000;
        end
        return word;
    endfunction

    // Next-state computation for the queue, the registered outputs and the counter.
    always_comb begin
        accept_s       = in_valid && in_ready_q;
        pop_s          = out_valid_q && out_ready;
        new_entry_s    = decode_onehot(code_in, enable);
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        decode_count_d = decode_count_q;

        case ({accept_s, pop_s})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = new_entry_s;
                end else begin
                    tail_d = new_entry_s;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Accept is only possible below 2 entries, so the queue was at 1 here.
                head_d = new_entry_s;
            end
            2'b00: begin
                head_d = head_q;
            end
            default: begin
                count_d = count_q;
            end
        endcase

        if (pop_s && (decoder_out_q != 16'h0000)) begin
            decode_count_d = decode_count_q + 8'd1;
        end else begin
            decode_count_d = decode_count_q;
        end

        in_ready_d  = (count_d < 2'd2);
        out_valid_d = (count_d != 2'd0);
        if (count_d != 2'd0) begin
            decoder_out_d = head_d;
        end else begin
            decoder_out_d = 16'h0000;
        end
    end

    // State register; reset clears the queue and wins over any accept or pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q         <= 16'h0000;
            tail_q         <= 16'h0000;
            count_q        <= 2'd0;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            decoder_out_q  <= 16'h0000;
            decode_count_q <= 8'd0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            decoder_out_q  <= decoder_out_d;
            decode_count_q <= decode_count_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign decoder_out  = decoder_out_q;
    assign decode_count = decode_count_q;

endmodule

// File: tb/tb_decoder_buf.sv
// Directed self-checking bench for decoder_buf: ordering, backpressure,
// zero entries, counter wrap and reset flush.
module tb_decoder_buf;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  code_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] decoder_out;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  decode_count;

    int checks;
    int failures;

    decoder_buf dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .code_in      (code_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .decoder_out  (decoder_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .decode_count (decode_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp_w;
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        enable    = 1'b1;
        code_in   = 4'h0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dout", 32'(decoder_out), 32'h0);
        chk("rst_count", 32'(decode_count), 32'd0);

        reset = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Streaming codes 0,4,8,C with out_ready=1
        out_ready = 1'b1;
        in_valid  = 1'b1;
        code_in   = 4'h0;
        step();
        chk("seq0_valid", 32'(out_valid), 32'd1);
        chk("seq0_dout", 32'(decoder_out), 32'h0001);
        chk("seq0_count", 32'(decode_count), 32'd0);
        code_in = 4'h4;
        step();
        chk("seq4_dout", 32'(decoder_out), 32'h0010);
        chk("seq4_count", 32'(decode_count), 32'd1);
        code_in = 4'h8;
        step();
        chk("seq8_dout", 32'(decoder_out), 32'h0100);
        chk("seq8_count", 32'(decode_count), 32'd2);
        code_in = 4'hC;
        step();
        chk("seqC_dout", 32'(decoder_out), 32'h1000);
        chk("seqC_count", 32'(decode_count), 32'd3);
        in_valid = 1'b0;
        step();
        chk("seq_drain_valid", 32'(out_valid), 32'd0);
        chk("seq_drain_dout", 32'(decoder_out), 32'h0);
        chk("seq_count4", 32'(decode_count), 32'd4);

        // enable=0 entry decodes as zero and does not count
        out_ready = 1'b0;
        enable    = 1'b0;
        code_in   = 4'h5;
        in_valid  = 1'b1;
        step();
        chk("zero_valid", 32'(out_valid), 32'd1);
        chk("zero_dout", 32'(decoder_out), 32'h0000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        enable    = 1'b1;
        step();
        chk("zero_popped_valid", 32'(out_valid), 32'd0);
        chk("zero_count_same", 32'(decode_count), 32'd4);

        // Backpressure: fill to 2, third code refused, output stable
        out_ready = 1'b0;
        in_valid  = 1'b1;
        code_in   = 4'h1;
        step();
        chk("bp1_dout", 32'(decoder_out), 32'h0002);
        chk("bp1_in_ready", 32'(in_ready), 32'd1);
        code_in = 4'h2;
        step();
        chk("bp2_in_ready", 32'(in_ready), 32'd0);
        chk("bp2_dout", 32'(decoder_out), 32'h0002);
        code_in = 4'h3;
        step();
        chk("bp3_in_ready", 32'(in_ready), 32'd0);
        chk("bp3_dout", 32'(decoder_out), 32'h0002);
        step();
        chk("bp3b_dout", 32'(decoder_out), 32'h0002);
        chk("bp3b_valid", 32'(out_valid), 32'd1);

        // Drain one, then push+pop on the same edge at occupancy 1
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("drain_dout", 32'(decoder_out), 32'h0004);
        chk("drain_count", 32'(decode_count), 32'd5);
        chk("drain_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        code_in  = 4'h6;
        step();
        chk("pp_valid", 32'(out_valid), 32'd1);
        chk("pp_dout", 32'(decoder_out), 32'h0040);
        chk("pp_count", 32'(decode_count), 32'd6);
        chk("pp_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        step();
        chk("pp_empty", 32'(out_valid), 32'd0);
        chk("pp_count2", 32'(decode_count), 32'd7);

        // Stream 248 nonzero words, bringing the count from 7 to 255
        in_valid = 1'b1;
        for (int i = 0; i < 248; i++) begin
            code_in = i[3:0];
            exp_w   = 16'h0001 << i[3:0];
            step();
            chk("stream_dout", 32'(decoder_out), 32'(exp_w));
        end
        in_valid = 1'b0;
        step();
        chk("stream_count255", 32'(decode_count), 32'd255);
        in_valid = 1'b1;
        code_in  = 4'hF;
        step();
        chk("codeF_dout", 32'(decoder_out), 32'h8000);
        chk("codeF_count", 32'(decode_count), 32'd255);
        in_valid = 1'b0;
        step();
        chk("wrap_count0", 32'(decode_count), 32'd0);

        // Reset with two entries queued, while accept and pop are requested
        in_valid = 1'b1;
        code_in  = 4'h1;
        step();
        in_valid = 1'b0;
        step();
        chk("pre_rst_count", 32'(decode_count), 32'd1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        code_in   = 4'h9;
        step();
        code_in = 4'hA;
        step();
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        chk("pre_rst_dout", 32'(decoder_out), 32'h0200);
        reset     = 1'b1;
        code_in   = 4'hB;
        out_ready = 1'b1;
        step();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_dout", 32'(decoder_out), 32'h0);
        chk("mid_rst_count", 32'(decode_count), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        chk("after_rst_in_ready", 32'(in_ready), 32'd1);
        chk("after_rst_valid", 32'(out_valid), 32'd0);
        step();
        chk("no_stale_valid", 32'(out_valid), 32'd0);
        chk("no_stale_dout", 32'(decoder_out), 32'h0);
        in_valid = 1'b1;
        code_in  = 4'h2;
        step();
        chk("fresh_dout", 32'(decoder_out), 32'h0004);
        in_valid = 1'b0;
        step();
        chk("fresh_empty", 32'(out_valid), 32'd0);
        chk("fresh_count", 32'(decode_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder_buf.md
DECODER_BUF -- requirements
Module: decoder_buf

Interface
REQ-001 The block SHALL have one clock domain and SHALL use a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 enable  input  1  sampled with each accepted code; 0 causes that entry to decode as all-zero.
REQ-005 code_in  input  4  binary index to decode.
REQ-006 in_valid  input  1  code_in/enable valid this cycle.
REQ-007 in_ready  output  1  block can accept a code this cycle.
REQ-008 decoder_out  output  16  one-hot decoded word at queue head.
REQ-009 out_valid  output  1  decoder_out holds a valid entry.
REQ-010 out_ready  input  1  downstream accepts decoder_out this cycle.
REQ-011 decode_count  output  8  number of delivered nonzero words, modulo 256.

Function
REQ-012 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; no other input state SHALL modify the queue.
REQ-013 On accept, the stored entry SHALL be (1 << code_in) if enable=1, else 16'h0000.
REQ-014 Storage SHALL be a 2-entry FIFO with an occupancy count of 0..2.
REQ-015 in_ready SHALL be 1 iff occupancy < 2; it SHALL NOT depend on out_ready (no full-bypass).
REQ-016 out_valid SHALL be 1 iff occupancy > 0.
REQ-017 decoder_out SHALL show the head entry while out_valid=1, and 16'h0000 while out_valid=0.
REQ-018 Latency: an entry accepted at edge N SHALL make out_valid=1 in the cycle after edge N when the queue was empty, giving exactly 1 cycle of latency.
REQ-019 Pop SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-020 Simultaneous accept and pop at occupancy 1 SHALL leave occupancy at 1, with the new entry becoming the head.
REQ-021 Entries SHALL be delivered in acceptance order with no loss and no duplication.
REQ-022 The output SHALL hold: while out_valid=1 and out_ready=0, decoder_out SHALL remain stable.
REQ-023 decode_count SHALL increment by 1 on each pop of a nonzero word.
REQ-024 decode_count SHALL wrap from 255 to 0.
REQ-025 A pop of a zero word SHALL leave decode_count unchanged.
REQ-026 At occupancy 2, in_valid=1 SHALL be ignored (no accept) until a pop lowers occupancy.
REQ-027 A code of 4'hF SHALL produce 16'h8000, and a code of 4'h0 SHALL produce 16'h0001.

Reset
REQ-028 While reset=1 at an edge, the block SHALL set occupancy=0, out_valid=0, decoder_out=16'h0000, and decode_count=0.
REQ-029 While reset is asserted, in_ready SHALL be 0; it SHALL become 1 in the first cycle after reset deasserts.
REQ-030 Reset mid-transfer SHALL discard all queued entries, and no pre-reset entry SHALL appear afterward.
REQ-031 Reset SHALL take priority over a simultaneous accept or pop.

Verification
REQ-032 After reset, apply enable=1, code 4'h0 then 4'h4 then 4'h8 then 4'hC with out_ready=1 -> decoder_out sequence 0x0001, 0x0010, 0x0100, 0x1000, each 1 cycle after accept, and decode_count=4.
REQ-033 Apply enable=0 with code 4'h5 -> entry 0x0000 delivered with out_valid=1 and decode_count unchanged.
REQ-034 Hold out_ready=0 and push codes 4'h1, 4'h2, 4'h3 -> in_ready=0 after the second accept, the third code is not taken, and decoder_out stays 0x0002.
REQ-035 Drain the queue, then push and pop on the same edge at occupancy 1 -> occupancy stays 1 and order is preserved.
REQ-036 Deliver 256 nonzero words -> decode_count wraps to 0.
REQ-037 Assert reset with 2 entries queued -> out_valid=0, decoder_out=0x0000, and decode_count=0 on the next cycle; no stale entry is delivered afterward.
